pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Supervises the board PLL (50 MHz refclk in; 125 MHz and 62.5 MHz out). Pulses the PLL reset, qualifies the PLL locked flag, and releases two downstream reset outputs in a staggered order, one per generated clock domain. Detects loss of lock and re-sequences automatically. Retries a failed lock a bounded number of times, then declares a sticky fault. Runs entirely on refclk.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before release (>=1)
LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK per attempt (10 ms at 50 MHz); must exceed LOCK_STABLE
LOSS_FILTER, 4, consecutive unlocked cycles in RUN that count as lock loss (>=1)
STAGGER, 8, cycles between rst_out_0 and rst_out_1 deassertion (>=1)
MAX_RETRIES, 3, timeouts tolerated before FAULT (<=15)

Ports:
refclk  in  1  free-running 50 MHz clock; all logic on this clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked flag, asynchronous; synchronized internally
sw_reset_req  in  1  single-cycle request to re-sequence; also clears FAULT
pll_rst  out  1  reset to PLL, active-high
rst_out_0  out  1  active-high reset for the 125 MHz domain; the downstream domain synchronizes it
rst_out_1  out  1  active-high reset for the 62.5 MHz domain
ready  out  1  high only in RUN
fault  out  1  sticky lock-failure indicator
retry_count  out  4  timeouts in the current sequence
state  out  3  current FSM state encoding, for debug

Behaviour:
- All outputs are registered. On rst: state=RESET_PLL, pll_rst=1, rst_out_0=1, rst_out_1=1, ready=0, fault=0, retry_count=0, all counters=0.
- lock_s is pll_locked passed through a 2-flop synchronizer, giving 2 cycles of latency. All decisions below use lock_s.
- RESET_PLL (0): pll_rst=1 and both rst_out=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK (1): pll_rst=0.
  - Stable counter increments while lock_s=1 and clears on lock_s=0.
  - Stable counter reaching LOCK_STABLE -> RELEASE.
  - Timeout counter counts cycles spent in the state. Reaching LOCK_TIMEOUT:
    - retry_count==MAX_RETRIES -> FAULT;
    - otherwise retry_count+1 and go to RESET_PLL.
  - If stable and timeout complete on the same cycle, RELEASE wins.
- RELEASE (2): rst_out_0=0 on entry. rst_out_1=0 exactly STAGGER cycles later; ready=1 and retry_count=0 on that same cycle, with transition to RUN. If lock_s=0 on any cycle here -> RESET_PLL with both rst_out=1 (no filter).
- RUN (3): both rst_out=0, ready=1. LOSS_FILTER consecutive cycles of lock_s=0 -> RESET_PLL: both rst_out=1 and ready=0 on the next edge. A shorter glitch only clears the loss counter.
- FAULT (4): pll_rst=1, both rst_out=1, fault=1, ready=0. Only sw_reset_req or rst leaves it: fault=0, retry_count=0, go to RESET_PLL.
- sw_reset_req in any non-FAULT state -> RESET_PLL next cycle with retry_count=0. It has priority over every other transition on the same cycle.
- rst asserted mid-sequence overrides everything and restores the reset values on the next edge.
- Counters saturate and never wrap. Counter width is clog2 of the largest of LOCK_TIMEOUT, LOCK_STABLE, RST_CYCLES, STAGGER, plus 1. All counters clear on every state entry.

Decomposition:
- Package pll_seq_pkg holds:
  - state encoding constants (RESET_PLL=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4);
  - the 3-bit state width;
  - a constant function for counter width.
- One sub-module, sync_2ff: a generic single-bit 2-flop synchronizer with no reset, used for pll_locked.

Test Plan:
Use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, LOSS_FILTER=3, STAGGER=2, MAX_RETRIES=2.
1. Nominal: release rst, raise pll_locked at cycle 10 -> pll_rst high for cycles 1-4; rst_out_0 falls at cycle 10+2+8+1; rst_out_1 and ready rise/fall 2 cycles later; retry_count=0.
2. Lock glitch: in WAIT_LOCK, pll_locked high 6 cycles, low 1, then high -> stable counter restarts; release occurs 8 synchronized-high cycles after the glitch.
3. Retry to fault: pll_locked held 0 -> three pll_rst pulses, retry_count 0->1->2, then FAULT with fault=1, pll_rst=1. A one-cycle sw_reset_req -> fault=0 and RESET_PLL.
4. Loss filter in RUN: pll_locked low 2 cycles -> stays in RUN. Low 3 cycles -> both rst_out=1, ready=0, state=RESET_PLL, then normal re-lock.
5. Priority: sw_reset_req on the same cycle the WAIT_LOCK timeout expires -> RESET_PLL with retry_count=0, not incremented.
6. rst asserted during RELEASE, between rst_out_0 and rst_out_1 deassertion -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: shared definitions for the PLL reset sequencer.
//   - FSM state encoding and width
//   - packed struct of the registered control outputs
//   - constant function sizing the internal cycle counters
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic pll_rst;
        logic rst_out_0;
        logic rst_out_1;
        logic ready;
        logic fault;
    } seq_out_t;

    // Counter width: one bit of headroom above the largest programmed count.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

    // Output levels held for the whole time the FSM sits in a state.
    function automatic seq_out_t state_outputs(input seq_state_e s);
        seq_out_t o;
        o = '0;
        case (s)
            RESET_PLL: begin o.pll_rst = 1'b1; o.rst_out_0 = 1'b1; o.rst_out_1 = 1'b1; end
            WAIT_LOCK: begin o.rst_out_0 = 1'b1; o.rst_out_1 = 1'b1; end
            RELEASE:   begin o.rst_out_1 = 1'b1; end
            RUN:       begin o.ready = 1'b1; end
            FAULT:     begin o.pll_rst = 1'b1; o.rst_out_0 = 1'b1; o.rst_out_1 = 1'b1; o.fault = 1'b1; end
            default:   begin o.pll_rst = 1'b1; o.rst_out_0 = 1'b1; o.rst_out_1 = 1'b1; end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer, no reset.
//   i_clk : destination clock
//   i_d   : asynchronous input
//   o_q   : synchronized output, two cycles of latency
module sync_2ff (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        r_meta <= i_d;
        r_sync <= r_meta;
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, qualifies lock, then releases the
// two generated-clock-domain resets in a staggered order. Re-sequences on lock
// loss, retries failed locks and latches a fault after too many timeouts.
//   refclk       : free-running reference clock, all logic on this clock
//   rst          : synchronous active-high reset
//   pll_locked   : asynchronous PLL lock flag
//   sw_reset_req : single-cycle re-sequence request, also clears FAULT
//   pll_rst      : PLL reset, active-high
//   rst_out_0/1  : downstream domain resets, active-high
//   ready        : high only in RUN
//   fault        : sticky lock-failure flag
//   retry_count  : timeouts in the current sequence
//   state        : current FSM state encoding
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 500000,
    parameter int unsigned LOSS_FILTER  = 4,
    parameter int unsigned STAGGER      = 8,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               sw_reset_req,
    output logic               pll_rst,
    output logic               rst_out_0,
    output logic               rst_out_1,
    output logic               ready,
    output logic               fault,
    output logic [3:0]         retry_count,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned CNT_W = cnt_width(LOCK_TIMEOUT, LOCK_STABLE, RST_CYCLES, STAGGER);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    seq_state_e       r_state;
    seq_out_t         r_out;
    logic [3:0]       r_retry;
    logic [CNT_W-1:0] r_cnt;   // cycles since state entry (RST/timeout/stagger)
    logic [CNT_W-1:0] r_aux;   // stable-lock count in WAIT_LOCK, loss count in RUN
    logic             w_lock_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sync_2ff u_lock_sync (
        .i_clk (refclk),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    // Sequencer FSM; every state entry reloads the outputs and clears both counters.
    always_ff @(posedge refclk) begin
        if (rst || sw_reset_req) begin
            // sw_reset_req shares the reset values: fault and retry_count clear too
            r_state <= RESET_PLL;
            r_out   <= state_outputs(RESET_PLL);
            r_retry <= '0;
            r_cnt   <= '0;
            r_aux   <= '0;
        end else begin
            r_cnt <= sat_inc(r_cnt);
            case (r_state)
                RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        r_state <= WAIT_LOCK;
                        r_out   <= state_outputs(WAIT_LOCK);
                        r_cnt   <= '0;
                        r_aux   <= '0;
                    end
                end
                WAIT_LOCK: begin
                    r_aux <= w_lock_s ? sat_inc(r_aux) : '0;
                    // Stable lock is tested before timeout so RELEASE wins a tie
                    if (r_aux >= STABLE_DONE) begin
                        r_state <= RELEASE;
                        r_out   <= state_outputs(RELEASE);
                        r_cnt   <= '0;
                        r_aux   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        if (r_retry == RETRY_MAX) begin
                            r_state <= FAULT;
                            r_out   <= state_outputs(FAULT);
                        end else begin
                            r_state <= RESET_PLL;
                            r_out   <= state_outputs(RESET_PLL);
                            r_retry <= r_retry + 4'd1;
                        end
                        r_cnt <= '0;
                        r_aux <= '0;
                    end
                end
                RELEASE: begin
                    // Any unlocked cycle aborts the release, no filtering here
                    if (!w_lock_s) begin
                        r_state <= RESET_PLL;
                        r_out   <= state_outputs(RESET_PLL);
                        r_cnt   <= '0;
                        r_aux   <= '0;
                    end else if (r_cnt == STAGGER_LAST) begin
                        r_state <= RUN;
                        r_out   <= state_outputs(RUN);
                        r_retry <= '0;
                        r_cnt   <= '0;
                        r_aux   <= '0;
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        if (r_aux == LOSS_LAST) begin
                            r_state <= RESET_PLL;
                            r_out   <= state_outputs(RESET_PLL);
                            r_cnt   <= '0;
                            r_aux   <= '0;
                        end else begin
                            r_aux <= sat_inc(r_aux);
                        end
                    end else begin
                        r_aux <= '0;
                    end
                end
                FAULT: begin
                    r_aux <= '0;
                end
                default: begin
                    r_state <= RESET_PLL;
                    r_out   <= state_outputs(RESET_PLL);
                    r_cnt   <= '0;
                    r_aux   <= '0;
                end
            endcase
        end
    end

    assign pll_rst     = r_out.pll_rst;
    assign rst_out_0   = r_out.rst_out_0;
    assign rst_out_1   = r_out.rst_out_1;
    assign ready       = r_out.ready;
    assign fault       = r_out.fault;
    assign retry_count = r_retry;
    assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed stimulus pushes time-stamped
// expected output vectors; a negedge monitor pops and compares them and flags
// any output change that was not expected.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    logic       refclk       = 1'b0;
    logic       rst          = 1'b1;
    logic       pll_locked   = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       pll_rst;
    logic       rst_out_0;
    logic       rst_out_1;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (64),
        .LOSS_FILTER  (3),
        .STAGGER      (2),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .pll_rst      (pll_rst),
        .rst_out_0    (rst_out_0),
        .rst_out_1    (rst_out_1),
        .ready        (ready),
        .fault        (fault),
        .retry_count  (retry_count),
        .state        (state)
    );

    always #10 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] ov;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en   = 1'b0;
    bit          have_prev = 1'b0;
    logic [11:0] mon_ov;
    logic [11:0] prev_ov;

    // Expected vector {state, pll_rst, rst_out_0, rst_out_1, ready, fault, retry}
    function automatic logic [11:0] vec(input int st, input int rt);
        logic [4:0] o;
        case (st)
            0:       o = 5'b11100;
            1:       o = 5'b01100;
            2:       o = 5'b00100;
            3:       o = 5'b00010;
            4:       o = 5'b11101;
            default: o = 5'b00000;
        endcase
        return {3'(st), o, 4'(rt)};
    endfunction

    task automatic expect_at(input int c, input string nm, input int st, input int rt);
        exp_t e;
        e.cyc  = c;
        e.ov   = vec(st, rt);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Monitor: compares due expectations, reports any other output change
    always @(negedge refclk) begin
        if (mon_en) begin
            mon_ov = {state, pll_rst, rst_out_0, rst_out_1, ready, fault, retry_count};
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (e.cyc != cyc || mon_ov !== e.ov) begin
                    n_errors++;
                    $display("FAIL %s: cycle %0d got state=%0d ctl=%b retry=%0d, expected cycle %0d state=%0d ctl=%b retry=%0d",
                             e.name, cyc, mon_ov[11:9], mon_ov[8:4], mon_ov[3:0],
                             e.cyc, e.ov[11:9], e.ov[8:4], e.ov[3:0]);
                end
            end else if (have_prev && mon_ov !== prev_ov) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_change: cycle %0d got state=%0d ctl=%b retry=%0d, expected unchanged state=%0d ctl=%b retry=%0d",
                         cyc, mon_ov[11:9], mon_ov[8:4], mon_ov[3:0],
                         prev_ov[11:9], prev_ov[8:4], prev_ov[3:0]);
            end
            prev_ov   = mon_ov;
            have_prev = 1'b1;
        end
    end

    initial begin
        #(20 * 5000);
        $display("FAIL watchdog: cycle %0d reached, expected finish by cycle 420", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Nominal bring-up: lock raised at cycle 10 after reset release
        wait_until(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        expect_at(3,  "reset_values",    0, 0);
        expect_at(7,  "nom_wait_lock",   1, 0);
        expect_at(23, "nom_release",     2, 0);
        expect_at(25, "nom_run",         3, 0);
        wait_until(12);
        pll_locked = 1'b1;

        // 2. sw_reset from RUN, then a one-cycle lock glitch in WAIT_LOCK
        expect_at(31, "sw_reset_run",    0, 0);
        expect_at(35, "glitch_wait",     1, 0);
        expect_at(54, "glitch_release",  2, 0);
        expect_at(56, "glitch_run",      3, 0);
        wait_until(30);
        sw_reset_req = 1'b1;
        pll_locked   = 1'b0;
        wait_until(31);
        sw_reset_req = 1'b0;
        wait_until(36);
        pll_locked = 1'b1;
        wait_until(42);
        pll_locked = 1'b0;
        wait_until(43);
        pll_locked = 1'b1;

        // 4. Loss filter: 2-cycle drop ignored, 3-cycle drop re-sequences
        expect_at(75, "loss_reset",      0, 0);
        expect_at(79, "loss_wait",       1, 0);
        expect_at(88, "loss_release",    2, 0);
        expect_at(90, "loss_run",        3, 0);
        wait_until(60);
        pll_locked = 1'b0;
        wait_until(62);
        pll_locked = 1'b1;
        wait_until(70);
        pll_locked = 1'b0;
        wait_until(73);
        pll_locked = 1'b1;

        // 3. Lock lost for good: retries then FAULT
        expect_at(100, "retry0_reset",   0, 0);
        expect_at(104, "retry0_wait",    1, 0);
        expect_at(168, "retry1_reset",   0, 1);
        expect_at(172, "retry1_wait",    1, 1);
        expect_at(236, "retry2_reset",   0, 2);
        expect_at(240, "retry2_wait",    1, 2);
        expect_at(304, "fault_entry",    4, 2);
        wait_until(95);
        pll_locked = 1'b0;

        // sw_reset clears FAULT
        expect_at(311, "fault_clear",    0, 0);
        expect_at(315, "clear_wait",     1, 0);
        wait_until(310);
        sw_reset_req = 1'b1;
        wait_until(311);
        sw_reset_req = 1'b0;

        // 5. sw_reset on the timeout cycle: retry_count stays 0
        expect_at(379, "prio_reset",     0, 0);
        expect_at(383, "prio_wait",      1, 0);
        wait_until(378);
        sw_reset_req = 1'b1;
        wait_until(379);
        sw_reset_req = 1'b0;

        // 6. rst between rst_out_0 and rst_out_1 release
        expect_at(395, "pre_rst_release", 2, 0);
        expect_at(396, "mid_release_rst", 0, 0);
        expect_at(400, "post_rst_wait",   1, 0);
        expect_at(409, "post_rst_release", 2, 0);
        expect_at(411, "post_rst_run",    3, 0);
        wait_until(384);
        pll_locked = 1'b1;
        wait_until(395);
        rst = 1'b1;
        wait_until(396);
        rst = 1'b0;

        wait_until(420);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
